// File: rtl/com_pkg.sv
// Shared definitions for the communication controller and its TX/RX datapaths.
package com_pkg;

  localparam int ADDR_W = 12;
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  typedef enum logic [3:0] {
    BAG_NONE = 4'h0,
    BAG_ACK  = 4'h1,
    BAG_NAK  = 4'h2,
    BAG_CMD  = 4'h3,
    BAG_DATA = 4'h4,
    BAG_STAT = 4'h5,
    BAG_DUMP = 4'hD
  } bag_e;

  // Major nibble 6 is reserved for the transmitter.
  typedef enum logic [7:0] {
    TX_IDLE  = 8'h60,
    TX_PREP  = 8'h61,
    TX_SYNC  = 8'h62,
    TX_HEAD  = 8'h63,
    TX_LENL  = 8'h64,
    TX_RD    = 8'h65,
    TX_LAT   = 8'h66,
    TX_DSEND = 8'h67,
    TX_CSUM  = 8'h68,
    TX_DONE  = 8'h69
  } tx_state_e;

  typedef struct packed {
    logic [3:0]        btype;
    logic [ADDR_W-1:0] rlen;
  } hdr_t;

  function automatic logic [7:0] head_byte(input hdr_t h);
    return {h.btype, h.rlen[ADDR_W-1:8]};
  endfunction

endpackage

// File: rtl/com_tx_if.sv
// Transmitter boundary: controller request/done, descriptor, TX RAM read port, byte stream.
interface com_tx_if;
  import com_pkg::*;

  logic              fs_tx;
  logic              fd_tx;
  logic [3:0]        tx_btype;
  logic [ADDR_W-1:0] tx_ram_init;
  logic [ADDR_W-1:0] tx_ram_rlen;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    input  fs_tx, tx_btype, tx_ram_init, tx_ram_rlen, ram_data, byte_ready,
    output fd_tx, ram_addr, byte_data, byte_valid
  );

  modport slave (
    output fs_tx, tx_btype, tx_ram_init, tx_ram_rlen, ram_data, byte_ready,
    input  fd_tx, ram_addr, byte_data, byte_valid
  );

endinterface

// File: rtl/com_tx_csum.sv
// 8-bit modulo-256 accumulator; sum updates one cycle after add_en, clr wins over add.
module com_tx_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/com_tx.sv
// Packet framer: SYNC, HEAD, LENL, RAM data, CSUM; 1 cycle per header byte, 3 per data byte.
// Holds byte_data/byte_valid steady under backpressure; outputs decode from registers only.
module com_tx
  import com_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  com_tx_if.master tx
);

  tx_state_e         state_q, state_d;
  hdr_t              hdr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_dec;
  logic [7:0]        data_q;
  logic [7:0]        sum;
  logic              st_valid;
  logic              xfer;
  logic              csum_clr;
  logic              csum_add;

  assign st_valid = (state_q inside {TX_SYNC, TX_HEAD, TX_LENL, TX_DSEND, TX_CSUM});
  assign xfer     = st_valid && tx.byte_ready;
  assign cnt_dec  = cnt_q - 12'd1;
  assign tx.ram_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (tx.fs_tx) state_d = TX_PREP;
      TX_PREP:  state_d = TX_SYNC;
      TX_SYNC:  if (xfer) state_d = TX_HEAD;
      TX_HEAD:  if (xfer) state_d = TX_LENL;
      TX_LENL:  if (xfer) state_d = (hdr_q.rlen != '0) ? TX_RD : TX_CSUM;
      TX_RD:    state_d = TX_LAT;
      TX_LAT:   state_d = TX_DSEND;
      TX_DSEND: if (xfer) state_d = (cnt_dec != '0) ? TX_RD : TX_CSUM;
      TX_CSUM:  if (xfer) state_d = TX_DONE;
      TX_DONE:  if (!tx.fs_tx) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx.byte_valid = st_valid;
    tx.fd_tx      = (state_q == TX_DONE);
    csum_clr      = (state_q == TX_PREP);
    csum_add      = xfer && (state_q inside {TX_HEAD, TX_LENL, TX_DSEND});
    case (state_q)
      TX_SYNC:  tx.byte_data = SYNC_BYTE;
      TX_HEAD:  tx.byte_data = head_byte(hdr_q);
      TX_LENL:  tx.byte_data = hdr_q.rlen[7:0];
      TX_DSEND: tx.byte_data = data_q;
      TX_CSUM:  tx.byte_data = sum;
      default:  tx.byte_data = 8'h00;
    endcase
  end

  // Descriptor is captured only in PREP so the controller may reuse tx_* once the packet is under way.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      data_q <= 8'h00;
    end else begin
      case (state_q)
        TX_PREP: begin
          hdr_q  <= '{btype: tx.tx_btype, rlen: tx.tx_ram_rlen};
          addr_q <= tx.tx_ram_init;
          cnt_q  <= tx.tx_ram_rlen;
        end
        TX_LAT: data_q <= tx.ram_data;
        TX_DSEND: begin
          if (xfer) begin
            addr_q <= addr_q + 12'd1;
            cnt_q  <= cnt_dec;
          end
        end
        default: ;
      endcase
    end
  end

  com_tx_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr    (csum_clr),
    .add_en (csum_add),
    .din    (tx.byte_data),
    .sum    (sum)
  );

endmodule

// File: tb/tb_com_tx.sv
// Directed bench for com_tx: packet-level byte model, per-cycle stream compare, literal pins.
module tb_com_tx;
  import com_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  com_tx_if bus();

  com_tx dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  typedef struct {
    logic [7:0]  b;
    bit          is_data;
    logic [11:0] addr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur_e;
  logic [7:0] mem [4096];
  int         vectors = 0;
  int         miscompares = 0;
  int         xfers = 0;
  int         valid_cycles = 0;
  int         rdy_mode = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_dat;

  // Synchronous-read TX RAM: data for ram_addr appears one cycle later.
  always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.byte_ready = 1'b1;
      1:       bus.byte_ready = 1'($urandom_range(0, 1));
      default: bus.byte_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected packet from the framing rules alone; returns the checksum.
  function automatic logic [7:0] build_pkt(input logic [3:0] bt, input logic [11:0] init,
                                           input logic [11:0] rlen);
    int         sum;
    logic [7:0] head;
    logic [11:0] a;
    head = {bt, rlen[11:8]};
    exp_q.push_back('{b: SYNC_BYTE, is_data: 1'b0, addr: 12'h0});
    exp_q.push_back('{b: head, is_data: 1'b0, addr: 12'h0});
    exp_q.push_back('{b: rlen[7:0], is_data: 1'b0, addr: 12'h0});
    sum = int'(head) + int'(rlen[7:0]);
    for (int i = 0; i < int'(rlen); i++) begin
      a = 12'((int'(init) + i) % 4096);
      exp_q.push_back('{b: mem[a], is_data: 1'b1, addr: a});
      sum += int'(mem[a]);
    end
    exp_q.push_back('{b: 8'(sum % 256), is_data: 1'b0, addr: 12'h0});
    return 8'(sum % 256);
  endfunction

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.byte_valid), 32'd1);
        chk("stall_data", 32'(bus.byte_data), 32'(prev_dat));
      end
      if (bus.byte_valid) valid_cycles++;
      if (bus.byte_valid && bus.byte_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte: got %0h want none", bus.byte_data);
        end else begin
          cur_e = exp_q.pop_front();
          chk("byte", 32'(bus.byte_data), 32'(cur_e.b));
          if (cur_e.is_data) chk("ram_addr", 32'(bus.ram_addr), 32'(cur_e.addr));
        end
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_dat   = bus.byte_data;
    end
  end

  // Runs one packet whose expectation is already queued.
  task automatic run_pkt(input logic [3:0] bt, input logic [11:0] init, input logic [11:0] rlen,
                         input int mode, input int exp_cycles, input int drop_at,
                         input int hold_after);
    int n;
    @(posedge clk); #1;
    rdy_mode = mode;
    xfers = 0;
    valid_cycles = 0;
    bus.tx_btype    = bt;
    bus.tx_ram_init = init;
    bus.tx_ram_rlen = rlen;
    bus.fs_tx       = 1'b1;
    n = 0;
    while (bus.fd_tx !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        bus.tx_btype    = ~bt;
        bus.tx_ram_init = ~init;
        bus.tx_ram_rlen = ~rlen;
      end
      if (n == drop_at) bus.fs_tx = 1'b0;
    end
    if (bus.fd_tx !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no fd_tx want fd_tx within 20000 cycles");
    end else begin
      if (exp_cycles >= 0) chk("done_cycle", 32'(n), 32'(exp_cycles));
      chk("xfer_count", 32'(xfers), 32'(int'(rlen) + 4));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < hold_after; i++) begin
        @(posedge clk); #1;
        chk("fd_hold", 32'(bus.fd_tx), 32'd1);
      end
      bus.fs_tx = 1'b0;
      @(posedge clk); #1;
      chk("fd_clear", 32'(bus.fd_tx), 32'd0);
      chk("idle_valid", 32'(bus.byte_valid), 32'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] cs;
    logic [7:0] lit1 [4];
    logic [7:0] lit2 [7];

    lit1 = '{8'h55, 8'h10, 8'h00, 8'h10};
    lit2 = '{8'h55, 8'hD0, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD9};
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 5);
    mem[12'h010] = 8'h01; mem[12'h011] = 8'h02; mem[12'h012] = 8'h03;
    mem[12'hFFE] = 8'hF0; mem[12'hFFF] = 8'h20; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;

    rst = 1'b1;
    bus.fs_tx = 1'b0;
    bus.tx_btype = 4'h0;
    bus.tx_ram_init = 12'h0;
    bus.tx_ram_rlen = 12'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fd", 32'(bus.fd_tx), 32'd0);
    chk("rst_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst_data", 32'(bus.byte_data), 32'h00);
    chk("rst_addr", 32'(bus.ram_addr), 32'h000);
    rst = 1'b0;

    // ACK with no payload
    cs = build_pkt(BAG_ACK, 12'h000, 12'd0);
    chk("t1_model_len", 32'(exp_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_model", 32'(exp_q[i].b), 32'(lit1[i]));
    run_pkt(BAG_ACK, 12'h000, 12'd0, 0, 6, -1, 3);
    chk("t1_valid_cycles", 32'(valid_cycles), 32'd4);

    // three-byte payload
    cs = build_pkt(4'hD, 12'h010, 12'd3);
    for (int i = 0; i < 7; i++) chk("t2_model", 32'(exp_q[i].b), 32'(lit2[i]));
    for (int i = 0; i < 3; i++) chk("t2_model_addr", 32'(exp_q[3 + i].addr), 32'h010 + 32'(i));
    run_pkt(4'hD, 12'h010, 12'd3, 0, 15, -1, 0);

    // address wrap 0xFFE..0x001
    cs = build_pkt(BAG_DATA, 12'hFFE, 12'd4);
    chk("t3_model_csum", 32'(cs), 32'hCB);
    chk("t3_model_addr2", 32'(exp_q[5].addr), 32'h000);
    chk("t3_model_addr3", 32'(exp_q[6].addr), 32'h001);
    run_pkt(BAG_DATA, 12'hFFE, 12'd4, 0, 18, -1, 0);

    // long packet under random backpressure, rlen[11:8] = 1
    cs = build_pkt(BAG_CMD, 12'h123, 12'd300);
    chk("t4_model_head", 32'(exp_q[1].b), 32'h31);
    chk("t4_model_lenl", 32'(exp_q[2].b), 32'h2C);
    run_pkt(BAG_CMD, 12'h123, 12'd300, 1, -1, -1, 0);

    // request withdrawn during the data phase
    cs = build_pkt(BAG_STAT, 12'h200, 12'd5);
    run_pkt(BAG_STAT, 12'h200, 12'd5, 0, 21, 8, 0);

    // reset while presenting the first data byte
    cs = build_pkt(BAG_NAK, 12'h300, 12'd4);
    @(posedge clk); #1;
    rdy_mode = 0;
    bus.tx_btype = BAG_NAK;
    bus.tx_ram_init = 12'h300;
    bus.tx_ram_rlen = 12'd4;
    bus.fs_tx = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", 32'(bus.byte_valid), 32'd1);
    chk("pre_rst_addr", 32'(bus.ram_addr), 32'h300);
    rst = 1'b1;
    bus.fs_tx = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(bus.byte_valid), 32'd0);
    chk("post_rst_fd", 32'(bus.fd_tx), 32'd0);
    chk("post_rst_addr", 32'(bus.ram_addr), 32'h000);
    exp_q.delete();
    rst = 1'b0;
    cs = build_pkt(BAG_NAK, 12'h400, 12'd2);
    run_pkt(BAG_NAK, 12'h400, 12'd2, 1, -1, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
